// File: rtl/sort_hw_ram_pipe_pkg.sv
// Shared definitions for the sort_hw on-chip RAM slave: system default sizes
// and the clear-engine state encodings.
package sort_hw_ram_pipe_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DEPTH  = 2048;

    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/sort_hw_ram_pipe_spram_core.sv
// Behavioural byte-enabled single-port array with a registered 1-cycle read,
// shaped so synthesis maps it onto block RAM (no reset on array or read port).
module sort_hw_spram_core
    import sort_hw_ram_pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic                  re,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int NB = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    // The read register only moves on a real read, so captured data survives
    // the clear sweep that may start right behind it.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < NB; b++) begin
                    if (be[b]) begin
                        mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
                    end
                end
            end
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/sort_hw_ram_pipe.sv
// Avalon-MM single-port RAM slave: request arbitration, zero-fill clear engine
// and a 1- or 2-cycle read-latency pipe around sort_hw_spram_core.
module sort_hw_ram_pipe
    import sort_hw_ram_pipe_pkg::*;
#(
    parameter int DATA_W         = DEF_DATA_W,
    parameter int ADDR_W         = DEF_ADDR_W,
    parameter int DEPTH          = DEF_DEPTH,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clken,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W/8-1:0]   byteenable,
    input  logic                  chipselect,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_W-1:0]     writedata,
    output logic [DATA_W-1:0]     readdata,
    output logic                  readdatavalid,
    output logic                  waitrequest,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic [0:0]            state,
    output logic [ADDR_W:0]       clr_addr
);

    localparam logic [ADDR_W:0] DEPTH_W     = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_ADDR   = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [0:0]      RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;

    logic                accept;
    logic                in_range;
    logic                wr_acc;
    logic                rd_acc;
    logic                core_we;
    logic                core_re;
    logic [DATA_W/8-1:0] core_be;
    logic [ADDR_W-1:0]   core_addr;
    logic [DATA_W-1:0]   core_wdata;
    logic [DATA_W-1:0]   core_rdata;
    logic                v1;
    logic                oor1;
    logic [DATA_W-1:0]   data1;

    // Handshake: a request is taken on an edge where chipselect and read or
    // write are high and waitrequest is low (waitrequest already folds in
    // clken and the clear sweep); a simultaneous read+write is a write only.
    assign clear_busy  = (state == ST_CLEAR);
    assign waitrequest = clear_busy | ~clken;
    assign accept      = chipselect & (read | write) & ~waitrequest;
    assign in_range    = ({1'b0, address} < DEPTH_W);
    assign wr_acc      = accept & write;
    assign rd_acc      = accept & read & ~write;

    assign core_we    = clear_busy | (wr_acc & in_range);
    assign core_re    = rd_acc & in_range;
    assign core_addr  = clear_busy ? clr_addr[ADDR_W-1:0] : address;
    assign core_be    = clear_busy ? '1 : byteenable;
    assign core_wdata = clear_busy ? '0 : writedata;

    sort_hw_spram_core #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk   (clk),
        .en    (clken),
        .we    (core_we),
        .re    (core_re),
        .be    (core_be),
        .addr  (core_addr),
        .wdata (core_wdata),
        .rdata (core_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= RESET_STATE;
            clr_addr <= '0;
        end else if (clken) begin
            case (state)
                ST_RUN: begin
                    if (clear_req) begin
                        state <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= ST_RUN;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                default: begin
                    state    <= ST_RUN;
                    clr_addr <= '0;
                end
            endcase
        end
    end

    // First pipe stage tracks the read the array is answering this cycle;
    // out-of-range reads still travel the pipe but are forced to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            v1   <= 1'b0;
            oor1 <= 1'b0;
        end else if (clken) begin
            v1   <= rd_acc;
            oor1 <= ~in_range;
        end
    end

    assign data1 = (v1 & ~oor1) ? core_rdata : '0;

    if (READ_LATENCY == 2) begin : g_lat2
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                readdatavalid <= 1'b0;
                readdata      <= '0;
            end else if (clken) begin
                readdatavalid <= v1;
                readdata      <= data1;
            end
        end
    end else begin : g_lat1
        assign readdatavalid = v1;
        assign readdata      = data1;
    end

endmodule

// File: tb/tb_sort_hw_ram_pipe.sv
// Self-checking bench: two instances (full-depth latency 1, short-depth latency 2)
// driven in lockstep and checked every cycle against an array/queue model.
module tb_sort_hw_ram_pipe;

    localparam int NDUT = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        clken;
    logic [10:0] address;
    logic [3:0]  byteenable;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic        clear_req;

    logic [31:0] rdata_w [NDUT];
    logic        rdv_w   [NDUT];
    logic        wreq_w  [NDUT];
    logic        busy_w  [NDUT];
    logic [0:0]  st_w    [NDUT];
    logic [11:0] caddr_w [NDUT];

    int dep [NDUT] = '{2048, 2000};
    int lat [NDUT] = '{1, 2};

    logic [31:0] mem_m [NDUT][2048];
    int          left_m [NDUT];
    logic [31:0] exp_q [NDUT][$];
    int          due_q [NDUT][$];
    int          cyc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sort_hw_ram_pipe #(
        .DATA_W(32), .ADDR_W(11), .DEPTH(2048), .READ_LATENCY(1), .CLEAR_ON_RESET(1)
    ) dut0 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(rdata_w[0]), .readdatavalid(rdv_w[0]),
        .waitrequest(wreq_w[0]), .clear_req(clear_req), .clear_busy(busy_w[0]),
        .state(st_w[0]), .clr_addr(caddr_w[0])
    );

    sort_hw_ram_pipe #(
        .DATA_W(32), .ADDR_W(11), .DEPTH(2000), .READ_LATENCY(2), .CLEAR_ON_RESET(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .clken(clken), .address(address),
        .byteenable(byteenable), .chipselect(chipselect), .read(read), .write(write),
        .writedata(writedata), .readdata(rdata_w[1]), .readdatavalid(rdv_w[1]),
        .waitrequest(wreq_w[1]), .clear_req(clear_req), .clear_busy(busy_w[1]),
        .state(st_w[1]), .clr_addr(caddr_w[1])
    );

    // Reference model: memory contents, remaining sweep length and the list of
    // reads owed to the bus with the cycle each one is due.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc = 0;
            for (int d = 0; d < NDUT; d++) begin
                left_m[d] = dep[d];
                exp_q[d].delete();
                due_q[d].delete();
                for (int i = 0; i < 2048; i++) mem_m[d][i] = '0;
            end
        end else if (clken) begin
            for (int d = 0; d < NDUT; d++) begin
                int  a;
                logic acc;
                a   = int'(address);
                acc = chipselect && (read || write) && (left_m[d] == 0);
                if (acc && write) begin
                    if (a < dep[d]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (byteenable[b]) mem_m[d][a][b*8 +: 8] = writedata[b*8 +: 8];
                        end
                    end
                end else if (acc && read) begin
                    exp_q[d].push_back((a < dep[d]) ? mem_m[d][a] : 32'h0);
                    due_q[d].push_back(cyc + lat[d]);
                end
                if (left_m[d] > 0) begin
                    left_m[d]--;
                end else if (clear_req) begin
                    left_m[d] = dep[d];
                    for (int i = 0; i < 2048; i++) mem_m[d][i] = '0;
                end
            end
            cyc++;
        end
    end

    // Per-cycle scoreboard, sampled mid-cycle.
    logic [31:0] exp_d;
    logic        exp_v;
    int          exp_ca;

    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            exp_v = 1'b0;
            exp_d = '0;
            if (due_q[d].size() > 0 && due_q[d][0] == cyc) begin
                exp_v = 1'b1;
                exp_d = exp_q[d].pop_front();
                void'(due_q[d].pop_front());
            end
            exp_ca = (left_m[d] > 0) ? dep[d] - left_m[d] : 0;

            checks++;
            assert (rdv_w[d] === exp_v) else begin
                errors++;
                $error("FAIL rdv dut%0d cyc %0d got %b want %b", d, cyc, rdv_w[d], exp_v);
            end
            checks++;
            assert (rdata_w[d] === exp_d) else begin
                errors++;
                $error("FAIL readdata dut%0d cyc %0d got %h want %h", d, cyc, rdata_w[d], exp_d);
            end
            checks++;
            assert (wreq_w[d] === ((left_m[d] > 0) || !clken)) else begin
                errors++;
                $error("FAIL waitrequest dut%0d cyc %0d got %b want %b", d, cyc, wreq_w[d],
                       ((left_m[d] > 0) || !clken));
            end
            checks++;
            assert (busy_w[d] === (left_m[d] > 0)) else begin
                errors++;
                $error("FAIL clear_busy dut%0d cyc %0d got %b want %b", d, cyc, busy_w[d],
                       (left_m[d] > 0));
            end
            checks++;
            assert (caddr_w[d] === 12'(exp_ca)) else begin
                errors++;
                $error("FAIL clr_addr dut%0d cyc %0d got %0d want %0d", d, cyc, caddr_w[d], exp_ca);
            end
        end
    end

    task automatic bus_op(input logic cs, input logic rd, input logic wr, input logic [10:0] a,
                          input logic [3:0] be, input logic [31:0] wd, input logic clr);
        chipselect = cs;
        read       = rd;
        write      = wr;
        address    = a;
        byteenable = be;
        writedata  = wd;
        clear_req  = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) bus_op(1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0, 1'b0);
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((left_m[0] > 0 || left_m[1] > 0) && n < limit) begin
            idle(1);
            n++;
        end
    endtask

    task automatic random_traffic(input int n);
        for (int i = 0; i < n; i++) begin
            int          r;
            logic [10:0] a;
            r = $urandom_range(0, 9);
            a = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(1990, 2047))
                                              : 11'($urandom_range(0, 2047));
            bus_op(($urandom_range(0, 7) != 0), (r <= 3) || (r == 8), (r >= 4 && r <= 8), a,
                   4'($urandom_range(0, 15)), $urandom, 1'b0);
        end
    endtask

    logic [10:0] addr_tbl [8] = '{11'd5, 11'd0, 11'd1999, 11'd2000, 11'd2047, 11'd1024, 11'd7, 11'd42};

    initial begin
        clken      = 1'b1;
        chipselect = 1'b0;
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        byteenable = '0;
        writedata  = '0;
        clear_req  = 1'b0;
        reset_n    = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        // Power-up sweep, then byte-lane merge on address 5.
        wait_idle(3000);
        bus_op(1'b1, 1'b0, 1'b1, 11'd5, 4'hF, 32'h11223344, 1'b0);
        bus_op(1'b1, 1'b0, 1'b1, 11'd5, 4'b0101, 32'hDEADBEEF, 1'b0);
        bus_op(1'b1, 1'b1, 1'b0, 11'd5, 4'h0, 32'h0, 1'b0);
        idle(4);

        // Back-to-back reads 0..7 after writing distinct data there.
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b0, 1'b1, 11'(i), 4'hF, $urandom, 1'b0);
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b1, 1'b0, 11'(i), 4'h0, 32'h0, 1'b0);
        idle(4);

        // Boundary addresses, read+write collision, then random traffic.
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b0, 1'b1, addr_tbl[i], 4'hF, $urandom, 1'b0);
        bus_op(1'b1, 1'b1, 1'b1, 11'd42, 4'hF, 32'hA5A5_5A5A, 1'b0);
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b1, 1'b0, addr_tbl[i], 4'h0, 32'h0, 1'b0);
        random_traffic(400);
        idle(4);

        // Clear request with reads in flight: they drain with the old data.
        for (int i = 0; i < 4; i++) bus_op(1'b1, 1'b1, 1'b0, addr_tbl[i], 4'h0, 32'h0, 1'b0);
        bus_op(1'b1, 1'b1, 1'b0, addr_tbl[4], 4'h0, 32'h0, 1'b1);
        bus_op(1'b1, 1'b1, 1'b0, addr_tbl[5], 4'h0, 32'h0, 1'b1);
        wait_idle(3000);
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b1, 1'b0, addr_tbl[i], 4'h0, 32'h0, 1'b0);
        random_traffic(100);
        idle(4);

        // Clock-enable stall in the middle of a sweep.
        bus_op(1'b0, 1'b0, 1'b0, 11'd0, 4'h0, 32'h0, 1'b1);
        idle(500);
        clken = 1'b0;
        idle(10);
        clken = 1'b1;
        wait_idle(3000);
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b1, 1'b0, addr_tbl[i], 4'h0, 32'h0, 1'b0);
        idle(4);

        // Reset aborts an in-flight read, then a second reset lands mid-sweep.
        bus_op(1'b1, 1'b0, 1'b1, 11'd3, 4'hF, 32'hCAFE_F00D, 1'b0);
        bus_op(1'b1, 1'b1, 1'b0, 11'd3, 4'h0, 32'h0, 1'b0);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        idle(700);
        reset_n = 1'b0;
        idle(2);
        reset_n = 1'b1;
        wait_idle(3000);
        for (int i = 0; i < 8; i++) bus_op(1'b1, 1'b1, 1'b0, addr_tbl[i], 4'h0, 32'h0, 1'b0);
        random_traffic(200);
        idle(6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
